// File: rtl/audio_stream_arbiter.sv
// Round-robin arbiter that shares one valid/ready audio sink between several stereo sources.
// Each grant covers a whole L/R frame. Misaligned right samples are dropped, and a stalled right channel times out.
module audio_stream_arbiter #(
  parameter int NUM_INPUTS     = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            i_valid,
  output logic [NUM_INPUTS-1:0]            i_ready,
  input  logic [NUM_INPUTS-1:0]            i_is_left,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_audio,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic                             o_is_left,
  output logic [DATA_WIDTH-1:0]            o_audio,
  output logic [$clog2(NUM_INPUTS)-1:0]    o_source,
  output logic                             is_error
);

  localparam int GW = $clog2(NUM_INPUTS);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t                state;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         cand;
  logic [GW-1:0]         scan_idx;
  logic                  cand_found;
  logic [CW-1:0]         counter;
  logic                  space;
  logic                  drop_err;
  logic                  grant_acc;
  logic [DATA_WIDTH-1:0] audio_arr [NUM_INPUTS];

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_unpack
    assign audio_arr[g] = i_audio[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign space     = !o_valid || o_ready;
  assign grant_acc = i_valid[grant] && i_ready[grant];

  // Search for a left-channel requester, starting just after the last source served.
  // The modulo makes the wrap work for any NUM_INPUTS.
  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    scan_idx   = '0;
    for (int off = 1; off <= NUM_INPUTS; off++) begin
      scan_idx = GW'((int'(last_grant) + off) % NUM_INPUTS);
      if (!cand_found && i_valid[scan_idx] && i_is_left[scan_idx]) begin
        cand_found = 1'b1;
        cand       = scan_idx;
      end
    end
  end

  // Only the granted source is offered space. Right samples that arrive out of frame order
  // are consumed without loading so their source can resynchronise.
  always_comb begin
    i_ready  = '0;
    drop_err = 1'b0;
    case (state)
      IDLE: begin
        i_ready  = i_valid & ~i_is_left;
        drop_err = |(i_valid & ~i_is_left);
      end
      LEFT: begin
        if (!i_is_left[grant]) begin
          i_ready[grant] = 1'b1;
          drop_err       = i_valid[grant];
        end else begin
          i_ready[grant] = space;
        end
      end
      RIGHT:   i_ready[grant] = space;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_INPUTS - 1);
      counter    <= '0;
      o_valid    <= 1'b0;
      o_is_left  <= 1'b0;
      o_audio    <= '0;
      o_source   <= '0;
      is_error   <= 1'b0;
    end else begin
      is_error <= drop_err;
      if (o_valid && o_ready) o_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cand_found) begin
            grant <= cand;
            state <= LEFT;
          end
        end
        LEFT: begin
          if (grant_acc && i_is_left[grant]) begin
            o_valid   <= 1'b1;
            o_is_left <= 1'b1;
            o_audio   <= audio_arr[grant];
            o_source  <= grant;
            counter   <= '0;
            state     <= RIGHT;
          end
        end
        RIGHT: begin
          if (grant_acc) begin
            o_valid   <= 1'b1;
            o_is_left <= i_is_left[grant];
            o_audio   <= audio_arr[grant];
            o_source  <= grant;
            // A repeated left sample restarts the wait for its right partner.
            if (i_is_left[grant]) begin
              is_error <= 1'b1;
              counter  <= '0;
            end else begin
              last_grant <= grant;
              state      <= IDLE;
            end
          end else if (counter == CW'(TIMEOUT_CYCLES - 1)) begin
            is_error   <= 1'b1;
            last_grant <= grant;
            counter    <= '0;
            state      <= IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
